// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package muldiv_pkg;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_FIN  = S_FIN,
        ST_DONE = S_DONE
    } muldiv_state_e;

    // MULHSU reads rs1 as signed but rs2 as unsigned, hence the separate helpers.
    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: add-and-shift multiply or restoring divide
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH:0]   hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        sum     = hi + (lo[0] ? {1'b0, operand} : '0);
        shifted = {hi[WIDTH-1:0], lo[WIDTH-1]};
        diff    = shifted - {1'b0, operand};
        hi_next = '0;
        lo_next = '0;
        if (is_div) begin
            // Remainder stays below the divisor, so diff[WIDTH] is a true sign bit.
            if (!diff[WIDTH]) begin
                hi_next = diff;
                lo_next = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_next = shifted;
                lo_next = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_next = {1'b0, sum[WIDTH:1]};
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit with early exits and flush
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             flush_i,
    input  logic [2:0]       funct3_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic             busy_o,
    output logic             valid_o,
    output logic [WIDTH-1:0] result_o
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    muldiv_state_e    state_q;
    muldiv_op_e       op_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] opd_q;
    logic             neg_main_q;
    logic             neg_rem_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;

    muldiv_op_e       op_in;
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic             div_zero;
    logic             div_ovf;
    logic [WIDTH-1:0] early_res;
    logic [WIDTH:0]   hi_next;
    logic [WIDTH-1:0] lo_next;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   fin_res;

    always_comb begin
        op_in    = muldiv_op_e'(funct3_i);
        sa       = op_signed_a(op_in) & op_a_i[WIDTH-1];
        sb       = op_signed_b(op_in) & op_b_i[WIDTH-1];
        abs_a    = sa ? -op_a_i : op_a_i;
        abs_b    = sb ? -op_b_i : op_b_i;
        div_zero = funct3_i[2] && (op_b_i == '0);
        div_ovf  = (op_in == OP_DIV || op_in == OP_REM) && (op_a_i == MIN_NEG) && (&op_b_i);
        // funct3[1] separates REM/REMU from DIV/DIVU in both corner cases.
        if (div_zero) begin
            early_res = funct3_i[1] ? op_a_i : '1;
        end else begin
            early_res = funct3_i[1] ? '0 : op_a_i;
        end
    end

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (op_q[2]),
        .hi      (hi_q),
        .lo      (lo_q),
        .operand (opd_q),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_comb begin
        prod     = {hi_q[WIDTH-1:0], lo_q};
        prod_fix = neg_main_q ? -prod : prod;
        quo_fix  = neg_main_q ? -lo_q : lo_q;
        rem_fix  = neg_rem_q ? -hi_q[WIDTH-1:0] : hi_q[WIDTH-1:0];
        case (op_q)
            OP_MUL:                       fin_res = prod_fix[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fin_res = quo_fix;
            default:                      fin_res = rem_fix;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_MUL;
            hi_q       <= '0;
            lo_q       <= '0;
            opd_q      <= '0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!flush_i && start_i) begin
                        op_q       <= op_in;
                        neg_main_q <= sa ^ sb;
                        neg_rem_q  <= sa;
                        cnt_q      <= CW'(WIDTH);
                        if (div_zero || div_ovf) begin
                            result_q <= early_res;
                            valid_q  <= 1'b1;
                            state_q  <= ST_DONE;
                        end else begin
                            // Divide shifts the dividend out of lo; multiply shifts the multiplier.
                            hi_q    <= '0;
                            lo_q    <= funct3_i[2] ? abs_a : abs_b;
                            opd_q   <= funct3_i[2] ? abs_b : abs_a;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        hi_q  <= hi_next;
                        lo_q  <= lo_next;
                        cnt_q <= cnt_q - CW'(1);
                        if (cnt_q == CW'(1)) begin
                            state_q <= ST_FIN;
                        end
                    end
                end
                ST_FIN: begin
                    if (flush_i) begin
                        state_q <= ST_IDLE;
                    end else begin
                        result_q <= fin_res;
                        valid_q  <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o   = (state_q == ST_CALC) || (state_q == ST_FIN);
    assign valid_o  = valid_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit against an arithmetic reference
module tb_muldiv_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic        flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int vectors = 0;
    int miscompares = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial forever #5 clk_i = ~clk_i;

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa64 = {{32{a[31]}}, a};
        logic [63:0] sb64 = {{32{b[31]}}, b};
        logic [63:0] ua64 = {32'd0, a};
        logic [63:0] ub64 = {32'd0, b};
        logic [63:0] p;
        int ia = a;
        int ib = b;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa64 * sb64; return p[31:0]; end
            3'd1: begin p = sa64 * sb64; return p[63:32]; end
            3'd2: begin p = sa64 * ub64; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_early(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        start_i  = 1'b1;
        funct3_i = f;
        op_a_i   = a;
        op_b_i   = b;
        @(negedge clk_i);
        start_i  = 1'b0;
    endtask

    task automatic wait_result(output int lat, output int busy_cnt, output bit seen);
        lat = 1;
        busy_cnt = 0;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (valid_o) begin
                seen = 1'b1;
                break;
            end
            if (busy_o) busy_cnt++;
            @(negedge clk_i);
            lat++;
        end
    endtask

    task automatic finish_check(input string tag, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] b, input int lat, input int busy_cnt, input bit seen);
        bit early = ref_early(f, a, b);
        check({tag, " seen"}, 32'(seen), 32'd1);
        check({tag, " result"}, result_o, ref_model(f, a, b));
        check({tag, " latency"}, lat, early ? 32'd1 : 32'd34);
        check({tag, " busy"}, busy_cnt, early ? 32'd0 : 32'd33);
        @(negedge clk_i);
        check({tag, " pulse"}, 32'(valid_o), 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat;
        int busy_cnt;
        bit seen;
        issue(f, a, b);
        wait_result(lat, busy_cnt, seen);
        finish_check(tag, f, a, b, lat, busy_cnt, seen);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int vcount;
        int bcount;
        bit seen;
        logic [31:0] prev;
        logic [2:0]  rf;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_ni = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'd0; op_a_i = '0; op_b_i = '0;
        repeat (3) @(negedge clk_i);
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset valid", 32'(valid_o), 32'd0);
        check("reset result", result_o, 32'd0);
        rst_ni = 1'b1;

        do_op("mul 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD);
        check("mul value", result_o, 32'hFFFF_FFEB);
        do_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulhu value", result_o, 32'hFFFF_FFFE);
        do_op("mulh", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("mulh value", result_o, 32'h0000_0000);
        do_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'd2);
        check("mulhsu value", result_o, 32'hFFFF_FFFF);
        do_op("div -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2);
        check("div value", result_o, 32'hFFFF_FFFD);
        do_op("rem -7/2", 3'd6, 32'hFFFF_FFF9, 32'd2);
        check("rem value", result_o, 32'hFFFF_FFFF);
        do_op("divu 100/7", 3'd5, 32'd100, 32'd7);
        check("divu value", result_o, 32'd14);
        do_op("divu by 0", 3'd5, 32'd5, 32'd0);
        check("divu0 value", result_o, 32'hFFFF_FFFF);
        do_op("remu by 0", 3'd7, 32'd5, 32'd0);
        check("remu0 value", result_o, 32'd5);
        do_op("div ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div ovf value", result_o, 32'h8000_0000);
        do_op("rem ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        check("rem ovf value", result_o, 32'd0);

        // Flush 10 cycles into a multiply
        prev = result_o;
        issue(3'd0, 32'd3, 32'd5);
        repeat (9) @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        check("flush busy", 32'(busy_o), 32'd0);
        check("flush valid", 32'(valid_o), 32'd0);
        check("flush result", result_o, prev);
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (valid_o) vcount++;
        end
        check("flush no pulse", vcount, 32'd0);
        check("flush result held", result_o, prev);
        do_op("divu 9/3", 3'd5, 32'd9, 32'd3);
        check("divu 9/3 value", result_o, 32'd3);

        // Reset 20 cycles into a divide, then start in the first cycle after release
        issue(3'd4, 32'hFFFF_FF00, 32'd3);
        repeat (19) @(negedge clk_i);
        rst_ni = 1'b0;
        #1;
        check("midreset busy", 32'(busy_o), 32'd0);
        check("midreset valid", 32'(valid_o), 32'd0);
        check("midreset result", result_o, 32'd0);
        @(negedge clk_i);
        rst_ni   = 1'b1;
        start_i  = 1'b1;
        funct3_i = 3'd5;
        op_a_i   = 32'd100;
        op_b_i   = 32'd7;
        @(negedge clk_i);
        start_i  = 1'b0;
        wait_result(lat, busy_cnt, seen);
        check("post reset seen", 32'(seen), 32'd1);
        check("post reset result", result_o, 32'd14);
        check("post reset latency", lat, 32'd34);

        // Start presented while DONE must be ignored
        start_i  = 1'b1;
        funct3_i = 3'd0;
        op_a_i   = 32'd3;
        op_b_i   = 32'd4;
        @(negedge clk_i);
        start_i  = 1'b0;
        vcount = 0;
        bcount = 0;
        for (int i = 0; i < 40; i++) begin
            if (valid_o) vcount++;
            if (busy_o) bcount++;
            @(negedge clk_i);
        end
        check("done start valid", vcount, 32'd0);
        check("done start busy", bcount, 32'd0);
        check("done start result", result_o, 32'd14);

        for (int n = 0; n < 40; n++) begin
            rf = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 5))
                0: ra = 32'h8000_0000;
                1: ra = 32'hFFFF_FFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 16));
                default: rb = $urandom;
            endcase
            do_op($sformatf("rand%0d f%0d", n, rf), rf, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
